// File: rtl/mcu_spi_target.sv
// mcu_spi_target: SPI mode-0 target (MSB first) bridging the MCU link to a byte stream.
// SCK/CSN/MOSI are oversampled in the clk domain. MOSI is deserialised into data_out,
// and the responder's data_in byte is serialised onto spi_miso.
//
// Ports:
//   clk, reset               core clock, async active-high reset
//   spi_clk/spi_csn/spi_mosi asynchronous SPI inputs from the MCU
//   spi_miso                 serial reply to the MCU, always driven
//   data_out_strobe          one-clk pulse when data_out holds a new byte
//   data_out_start           set with the strobe for the first byte of a CSN frame
//   data_out                 last received byte
//   data_in                  reply byte, loaded in IDLE and again 2 clk after each strobe
//   timeout                  one-clk pulse when a stalled partial byte is realigned
//
// Optional feature macro: SPI_TIMEOUT_EN. It adds the idle counter and the realignment
// of the bit counter. When the macro is undefined, timeout is tied low.
`timescale 1ns/1ps
module mcu_spi_target #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_out_strobe,
    output logic       data_out_start,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic       sck_prev, csn_prev;
    logic       sck_s, csn_s, mosi_s;
    logic       sck_rise, sck_fall, csn_fall;
    logic [2:0] bit_cnt;
    logic       first_byte;
    logic [7:0] rx;
    logic [7:0] tx;
    logic       strobe_d1;
    logic       load_idle, rx_shift, byte_done, tx_shift, tx_load, realign;

    // Input synchronisers plus one extra sample for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            csn_prev  <= csn_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign csn_fall = ~csn_s & csn_prev;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath controls; a CSN rise suppresses every SCK action in that clk
    always_comb begin
        state_next = state;
        load_idle  = 1'b0;
        rx_shift   = 1'b0;
        byte_done  = 1'b0;
        tx_shift   = 1'b0;
        tx_load    = 1'b0;
        case (state)
            IDLE: begin
                load_idle = 1'b1;
                if (csn_fall) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (csn_s) begin
                    state_next = IDLE;
                end else begin
                    rx_shift  = sck_rise;
                    byte_done = sck_rise && (bit_cnt == 3'd7);
                    // The falling edge that ends a byte must not shift out the freshly loaded reply MSB
                    tx_shift  = sck_fall && (bit_cnt != 3'd0);
                    tx_load   = strobe_d1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned IDLE_W = 16;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt;

    // Saturating count of clks since the last SCK edge inside a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) || sck_rise || sck_fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_comb begin
        realign = (state == SHIFT) && !csn_s && !sck_rise && !sck_fall &&
                  (bit_cnt != 3'd0) && (idle_cnt >= IDLE_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= realign;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign realign = 1'b0;
    assign timeout = 1'b0;
`endif

    // Receive/transmit datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_strobe <= 1'b0;
            data_out_start  <= 1'b0;
            data_out        <= 8'h00;
            strobe_d1       <= 1'b0;
            bit_cnt         <= 3'd0;
            first_byte      <= 1'b1;
            rx              <= 8'h00;
            tx              <= 8'h00;
        end else begin
            data_out_strobe <= byte_done;
            data_out_start  <= byte_done & first_byte;
            strobe_d1       <= data_out_strobe;
            if (byte_done) begin
                data_out <= {rx[6:0], mosi_s};
            end
            if (load_idle) begin
                bit_cnt    <= 3'd0;
                first_byte <= 1'b1;
            end else if (rx_shift) begin
                rx      <= {rx[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    first_byte <= 1'b0;
                end
            end else if (realign) begin
                bit_cnt <= 3'd0;
                rx      <= 8'h00;
            end
            if (load_idle || tx_load) begin
                tx <= data_in;
            end else if (tx_shift) begin
                tx <= {tx[6:0], 1'b0};
            end
        end
    end

    assign spi_miso = tx[7];

endmodule

// File: tb/tb_mcu_spi_target.sv
// Bench for mcu_spi_target: table of SPI frames plus directed multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_mcu_spi_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk, spi_csn, spi_mosi, spi_miso;
    logic       data_out_strobe, data_out_start, timeout;
    logic [7:0] data_out, data_in;

    logic [7:0] din_val, resp_val;
    logic [8:0] rxq[$];
    int         to_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        int              n;
        logic [2:0][7:0] mosi;   // mosi[0] is sent first
        logic [7:0]      din;    // data_in at CSN fall
        logic [7:0]      resp;   // responder reply after each strobe
    } frame_t;

    always #5 clk = ~clk;

    mcu_spi_target #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_clk        (spi_clk),
        .spi_csn        (spi_csn),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .data_out_strobe(data_out_strobe),
        .data_out_start (data_out_start),
        .data_out       (data_out),
        .data_in        (data_in),
        .timeout        (timeout)
    );

    // Record every strobe as {start, data}, and count timeout pulses
    initial begin
        to_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset && data_out_strobe) rxq.push_back({data_out_start, data_out});
            if (!reset && timeout) to_cnt++;
        end
    end

    // Responder: registers its reply one clk after a strobe; follows din_val between frames
    initial begin
        data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && data_out_strobe) begin
                @(posedge clk);
                #1;
                data_in = resp_val;
            end else if (spi_csn) begin
                data_in = din_val;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 0: MOSI set while SCK low, MISO captured just before SCK rises, half period 8 clk
    task automatic spi_bits(input logic [7:0] val, input int nbits, output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = val[7-i];
            wclk(8);
            mb[7-i] = spi_miso;
            spi_clk = 1'b1;
            wclk(8);
            spi_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        int         base;
        logic [7:0] m;
        logic [8:0] e;
        din_val  = f.din;
        resp_val = f.resp;
        wclk(4);
        base = rxq.size();
        spi_csn = 1'b0;
        wclk(8);
        for (int i = 0; i < f.n; i++) begin
            spi_bits(f.mosi[i], 8, m);
            check($sformatf("%s miso%0d", tag, i), 32'(m), 32'((i == 0) ? f.din : f.resp));
        end
        wclk(8);
        spi_csn = 1'b1;
        wclk(10);
        check($sformatf("%s strobes", tag), 32'(rxq.size() - base), 32'(f.n));
        for (int i = 0; i < f.n; i++) begin
            e = (base + i < rxq.size()) ? rxq[base+i] : 9'bx;
            check($sformatf("%s data%0d", tag, i), 32'(e[7:0]), 32'(f.mosi[i]));
            check($sformatf("%s start%0d", tag, i), 32'(e[8]), 32'(i == 0));
        end
    endtask

    frame_t     vecs[4];
    frame_t     f;
    int         base;
    int         tbase;
    logic [7:0] m;

    initial begin
        vecs[0] = '{n: 1, mosi: {8'h00, 8'h00, 8'hA5}, din: 8'h3C, resp: 8'h00};
        vecs[1] = '{n: 3, mosi: {8'h22, 8'h11, 8'h00}, din: 8'hF0, resp: 8'h96};
        vecs[2] = '{n: 2, mosi: {8'h00, 8'hC3, 8'h5A}, din: 8'h5C, resp: 8'h42};
        vecs[3] = '{n: 2, mosi: {8'h00, 8'h01, 8'hFF}, din: 8'h81, resp: 8'h7E};

        reset = 1'b1; spi_clk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        din_val = 8'h00; resp_val = 8'h00;
        wclk(3);
        check("reset strobe", 32'(data_out_strobe), 32'h0);
        check("reset start", 32'(data_out_start), 32'h0);
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset miso", 32'(spi_miso), 32'h0);
        check("reset timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        wclk(4);

        // IDLE: MISO reflects data_in[7]
        din_val = 8'h80;
        wclk(4);
        check("idle miso", 32'(spi_miso), 32'h1);

        for (int v = 0; v < 4; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

        // Partial byte dropped on CSN rise, next frame flagged as start
        din_val = 8'h00;
        wclk(4);
        base = rxq.size();
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'hFF, 5, m);
        wclk(8);
        spi_csn = 1'b1;
        wclk(10);
        check("partial strobes", 32'(rxq.size() - base), 32'h0);
        f = '{n: 1, mosi: {8'h00, 8'h00, 8'h3C}, din: 8'h00, resp: 8'h00};
        run_frame(f, "after_partial");

        // CSN rise coincides with the 8th SCK rise: no strobe
        base = rxq.size();
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'h55, 7, m);
        spi_mosi = 1'b1;
        wclk(8);
        spi_clk = 1'b1;
        spi_csn = 1'b1;
        wclk(10);
        spi_clk = 1'b0;
        wclk(10);
        check("coincident strobes", 32'(rxq.size() - base), 32'h0);
        f = '{n: 1, mosi: {8'h00, 8'h00, 8'hE7}, din: 8'hA9, resp: 8'h00};
        run_frame(f, "after_coincident");

        // Back-to-back frames separated by one clk of CSN high
        base = rxq.size();
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'h12, 8, m);
        wclk(8);
        spi_csn = 1'b1;
        wclk(1);
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'h34, 8, m);
        wclk(8);
        spi_csn = 1'b1;
        wclk(10);
        check("b2b strobes", 32'(rxq.size() - base), 32'h2);
        check("b2b first", 32'((rxq.size() > base) ? rxq[base] : 9'bx), 32'({1'b1, 8'h12}));
        check("b2b second", 32'((rxq.size() > base + 1) ? rxq[base+1] : 9'bx), 32'({1'b1, 8'h34}));

        // Stall after 3 bits, then a full byte
        base  = rxq.size();
        tbase = to_cnt;
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'hA0, 3, m);
        wclk(120);
        spi_bits(8'h81, 8, m);
        wclk(8);
        spi_csn = 1'b1;
        wclk(10);
        check("stall strobes", 32'(rxq.size() - base), 32'h1);
`ifdef SPI_TIMEOUT_EN
        check("stall byte", 32'((rxq.size() > base) ? rxq[base] : 9'bx), 32'({1'b1, 8'h81}));
        check("stall timeouts", 32'(to_cnt - tbase), 32'h1);
`else
        check("stall byte", 32'((rxq.size() > base) ? rxq[base] : 9'bx), 32'({1'b1, 8'hB0}));
        check("stall timeouts", 32'(to_cnt - tbase), 32'h0);
`endif

        // Async reset in the middle of a byte
        spi_csn = 1'b0;
        wclk(8);
        spi_bits(8'hF0, 4, m);
        spi_mosi = 1'b1;
        wclk(8);
        spi_clk = 1'b1;
        wclk(3);
        #2;
        reset = 1'b1;
        #1;
        check("midreset strobe", 32'(data_out_strobe), 32'h0);
        check("midreset start", 32'(data_out_start), 32'h0);
        check("midreset data_out", 32'(data_out), 32'h00);
        check("midreset miso", 32'(spi_miso), 32'h0);
        check("midreset timeout", 32'(timeout), 32'h0);
        wclk(2);
        spi_clk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        wclk(1);
        reset = 1'b0;
        wclk(4);
        f = '{n: 1, mosi: {8'h00, 8'h00, 8'hFF}, din: 8'h00, resp: 8'h00};
        run_frame(f, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
